// File: rtl/opb_reg_share_arbiter_if.sv
// Bus bundle between fabric requesters and the shared simulink2ppc register pair.
interface opb_reg_share_arbiter_if #(
  parameter int unsigned N_REQ = 4
);
  logic [N_REQ-1:0]    req;
  logic [N_REQ*32-1:0] req_data;
  logic [N_REQ-1:0]    gnt;
  logic                sw_ack;
  logic [31:0]         user_data_out;
  logic [31:0]         status_out;

  // Requesters and software side drive this view.
  modport master (
    output req, req_data, sw_ack,
    input  gnt, user_data_out, status_out
  );

  // Arbiter view.
  modport slave (
    input  req, req_data, sw_ack,
    output gnt, user_data_out, status_out
  );
endinterface

// File: rtl/opb_reg_share_arbiter.sv
// Round-robin arbiter sharing one simulink2ppc register pair among N_REQ requesters.
// A granted word is held until software toggles sw_ack (after a minimum hold time)
// or until the optional ack timeout forces release.
module opb_reg_share_arbiter #(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned ACK_TIMEOUT = 65535
) (
  input  logic                          OPB_Clk,
  input  logic                          OPB_Rst,
  opb_reg_share_arbiter_if.slave        bus_io
);

  localparam int unsigned PtrW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned HoldW = $clog2(HOLD_CYCLES + 1);
  localparam int unsigned ToW   = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;

  typedef enum logic [0:0] {StIdle, StWaitAck} state_e;

  state_e           state_q, state_d;
  logic [PtrW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [15:0]      seq_q, seq_d;
  logic [6:0]       tcnt_q, tcnt_d;
  logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
  logic [ToW-1:0]   wait_cnt_q, wait_cnt_d;
  logic             ack_pend_q, ack_pend_d;
  logic             ack_prev_q;
  logic             ack_init_q;
  logic             valid_q, valid_d;
  logic [2:0]       src_id_q, src_id_d;
  logic [31:0]      data_q, data_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;

  logic             sel_found;
  logic [2:0]       sel_idx;
  logic             ack_toggle;
  logic             ack_seen;
  logic             hold_done;
  logic             to_hit;

  // ack_prev is only meaningful after its first load following reset release.
  assign ack_toggle = ack_init_q && (bus_io.sw_ack != ack_prev_q);
  assign ack_seen   = ack_pend_q || ack_toggle;
  assign hold_done  = (hold_cnt_q >= HoldW'(HOLD_CYCLES - 1));
  assign to_hit     = (ACK_TIMEOUT != 0) && (wait_cnt_q >= ToW'(ACK_TIMEOUT - 1));

  // Circular search for the first active request starting at rr_ptr.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int k = 0; k < int'(N_REQ); k++) begin
      if (!sel_found && bus_io.req[(int'(rr_ptr_q) + k) % int'(N_REQ)]) begin
        sel_found = 1'b1;
        sel_idx   = 3'((int'(rr_ptr_q) + k) % int'(N_REQ));
      end
    end
  end

  // Next-state logic for the grant/hold/release FSM and its datapath.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    seq_d      = seq_q;
    tcnt_d     = tcnt_q;
    hold_cnt_d = hold_cnt_q;
    wait_cnt_d = wait_cnt_q;
    ack_pend_d = ack_pend_q;
    valid_d    = valid_q;
    src_id_d   = src_id_q;
    data_d     = data_q;
    gnt_d      = '0;

    unique case (state_q)
      StIdle: begin
        // Toggles seen here only advance ack_prev; they never pre-ack the next word.
        if (sel_found) begin
          data_d     = bus_io.req_data[32*sel_idx +: 32];
          src_id_d   = sel_idx;
          seq_d      = seq_q + 16'd1;
          valid_d    = 1'b1;
          gnt_d      = N_REQ'(1) << sel_idx;
          rr_ptr_d   = PtrW'((int'(sel_idx) + 1) % int'(N_REQ));
          hold_cnt_d = '0;
          wait_cnt_d = '0;
          ack_pend_d = 1'b0;
          state_d    = StWaitAck;
        end
      end
      StWaitAck: begin
        if (hold_cnt_q < HoldW'(HOLD_CYCLES)) hold_cnt_d = hold_cnt_q + HoldW'(1);
        if ((ACK_TIMEOUT != 0) && (wait_cnt_q < ToW'(ACK_TIMEOUT))) begin
          wait_cnt_d = wait_cnt_q + ToW'(1);
        end
        if (ack_toggle) ack_pend_d = 1'b1;

        if (hold_done && ack_seen) begin
          valid_d = 1'b0;
          state_d = StIdle;
        end else if (to_hit && !ack_seen) begin
          // Forced release; an ack in the same cycle would have taken the branch above.
          valid_d = 1'b0;
          state_d = StIdle;
          if (tcnt_q != 7'h7F) tcnt_d = tcnt_q + 7'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge OPB_Clk or negedge OPB_Rst) begin
    if (!OPB_Rst) begin
      state_q    <= StIdle;
      rr_ptr_q   <= '0;
      seq_q      <= '0;
      tcnt_q     <= '0;
      hold_cnt_q <= '0;
      wait_cnt_q <= '0;
      ack_pend_q <= 1'b0;
      ack_prev_q <= 1'b0;
      ack_init_q <= 1'b0;
      valid_q    <= 1'b0;
      src_id_q   <= '0;
      data_q     <= '0;
      gnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      seq_q      <= seq_d;
      tcnt_q     <= tcnt_d;
      hold_cnt_q <= hold_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      ack_pend_q <= ack_pend_d;
      ack_prev_q <= bus_io.sw_ack;
      ack_init_q <= 1'b1;
      valid_q    <= valid_d;
      src_id_q   <= src_id_d;
      data_q     <= data_d;
      gnt_q      <= gnt_d;
    end
  end

  // Register outputs straight onto the bus.
  always_comb begin
    bus_io.gnt           = gnt_q;
    bus_io.user_data_out = data_q;
    bus_io.status_out    = {valid_q, tcnt_q, 5'b0, src_id_q, seq_q};
  end

endmodule

// File: tb/tb_opb_reg_share_arbiter.sv
// Scoreboard bench for opb_reg_share_arbiter: grants are predicted into a queue
// and checked by an independent monitor; release timing is checked inline.
module tb_opb_reg_share_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  opb_reg_share_arbiter_if #(.N_REQ(4)) bus ();

  opb_reg_share_arbiter #(
    .N_REQ      (4),
    .HOLD_CYCLES(16),
    .ACK_TIMEOUT(32)
  ) dut (
    .OPB_Clk(clk),
    .OPB_Rst(rst_n),
    .bus_io (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  gnt;
    logic [31:0] data;
    logic [31:0] status;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endfunction

  function automatic logic [31:0] mk_status(logic v, logic [6:0] t, logic [2:0] s,
                                            logic [15:0] q);
    return {v, t, 5'b0, s, q};
  endfunction

  // Monitor: every grant pulse must match the next predicted word.
  always @(negedge clk) begin
    if (bus.gnt != '0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_gnt", {28'd0, bus.gnt}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_gnt", {28'd0, bus.gnt}, {28'd0, e.gnt});
        chk("sb_data", bus.user_data_out, e.data);
        chk("sb_status", bus.status_out, e.status);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Ticks until valid drops; n is the number of edges after the grant edge.
  task automatic wait_release(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.status_out[31] && n < 200);
    if (bus.status_out[31]) begin
      n_chk++;
      n_fail++;
      $display("FAIL release_bound: valid still 1 after %0d cycles", n);
    end
  endtask

  exp_t e;
  int   n;

  initial begin
    bus.req      = '0;
    bus.req_data = '0;
    bus.sw_ack   = 1'b0;

    // Reset state.
    #2 rst_n = 1'b0;
    #1;
    chk("rst_gnt", {28'd0, bus.gnt}, 32'd0);
    chk("rst_data", bus.user_data_out, 32'd0);
    chk("rst_status", bus.status_out, 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Single word, ack 3 cycles after grant, release held off by hold time.
    bus.req_data[31:0] = 32'hDEADBEEF;
    bus.req = 4'b0001;
    e.gnt = 4'b0001; e.data = 32'hDEADBEEF; e.status = 32'h80000001;
    exp_q.push_back(e);
    tick();
    chk("lat_gnt", {28'd0, bus.gnt}, 32'd1);
    bus.req = 4'b0000;
    for (int j = 1; j <= 16; j++) begin
      tick();
      if (j == 3) bus.sw_ack = ~bus.sw_ack;
      if (j == 15) chk("hold_valid", {31'd0, bus.status_out[31]}, 32'd1);
      if (j == 16) chk("hold_release", {31'd0, bus.status_out[31]}, 32'd0);
    end
    chk("keep_data", bus.user_data_out, 32'hDEADBEEF);
    chk("keep_status", bus.status_out, 32'h00000001);
    repeat (20) tick();

    // All four requesting continuously: strict round-robin.
    do_reset();
    for (int i = 0; i < 4; i++) bus.req_data[32*i +: 32] = 32'hA0000000 + i * 32'h111;
    bus.req = 4'b1111;
    for (int w = 0; w < 5; w++) begin
      e.gnt    = 4'b0001 << (w % 4);
      e.data   = 32'hA0000000 + (w % 4) * 32'h111;
      e.status = mk_status(1'b1, 7'd0, 3'(w % 4), 16'(w + 1));
      exp_q.push_back(e);
      tick();
      bus.sw_ack = ~bus.sw_ack;
      wait_release(n);
      chk("rr_hold_cycles", n, 32'd16);
    end
    bus.req = 4'b0000;
    repeat (3) tick();

    // Timeouts without ack, saturating at 127.
    do_reset();
    bus.req_data[95:64] = 32'hC0FFEE00;
    bus.req = 4'b0100;
    for (int w = 1; w <= 128; w++) begin
      e.gnt    = 4'b0100;
      e.data   = 32'hC0FFEE00;
      e.status = mk_status(1'b1, (w - 1 > 127) ? 7'd127 : 7'(w - 1), 3'd2, 16'(w));
      exp_q.push_back(e);
      tick();
      wait_release(n);
      chk("to_cycles", n, 32'd32);
      if (w == 1) chk("to_first_status", bus.status_out, 32'h01020001);
    end
    bus.req = 4'b0000;
    chk("to_saturated", bus.status_out, 32'h7F020080);
    repeat (3) tick();

    // Toggles in IDLE must not pre-acknowledge the next word.
    do_reset();
    bus.req_data[63:32] = 32'h5A5A5A5A;
    bus.sw_ack = ~bus.sw_ack;
    tick();
    bus.sw_ack = ~bus.sw_ack;
    tick();
    bus.sw_ack = ~bus.sw_ack;
    bus.req = 4'b0010;
    e.gnt = 4'b0010; e.data = 32'h5A5A5A5A; e.status = 32'h80010001;
    exp_q.push_back(e);
    tick();
    bus.req = 4'b0000;
    repeat (20) tick();
    chk("stale_hold", {31'd0, bus.status_out[31]}, 32'd1);
    bus.sw_ack = ~bus.sw_ack;
    tick();
    chk("fresh_release", bus.status_out, 32'h00010001);
    repeat (3) tick();

    // Sequence wrap, then asynchronous reset mid-WAIT_ACK.
    do_reset();
    force dut.seq_q = 16'hFFFF;
    #1;
    release dut.seq_q;
    bus.req_data[31:0] = 32'h12345678;
    bus.req = 4'b0001;
    e.gnt = 4'b0001; e.data = 32'h12345678; e.status = 32'h80000000;
    exp_q.push_back(e);
    tick();
    bus.req = 4'b0000;
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_gnt", {28'd0, bus.gnt}, 32'd0);
    chk("async_rst_data", bus.user_data_out, 32'd0);
    chk("async_rst_status", bus.status_out, 32'd0);
    bus.req = 4'b1111;
    repeat (5) tick();
    chk("rst_no_gnt", {28'd0, bus.gnt}, 32'd0);
    bus.req = 4'b0000;
    rst_n = 1'b1;
    repeat (5) tick();

    chk("sb_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/opb_reg_share_arbiter.md
Name: opb_reg_share_arbiter

Overview:
- Round-robin arbiter that shares one simulink2ppc software register pair among N_REQ fabric requesters.
- A granted requester's 32-bit word is latched onto user_data_out; a status word carries valid, source ID, sequence number and timeout count. Both feed opb_register_simulink2ppc user_data_in ports.
- Software acknowledges each word by toggling a bit in a ppc2simulink register (sw_ack). The arbiter then frees the register for the next requester.
- Sits in the fabric between status/capture sources and the PPC register bank; everything runs on OPB_Clk.

Parameters:
- N_REQ, 4, number of requesters; legal range 1..8.
- HOLD_CYCLES, 16, minimum cycles a word is held valid before release; legal range >= 1.
- ACK_TIMEOUT, 65535, cycles to wait for sw_ack before forced release; 0 = wait forever.

Ports:
- OPB_Clk  in  1  single clock for all logic.
- OPB_Rst  in  1  asynchronous reset, active-low (0 = reset).
- req  in  N_REQ  per-requester request level.
- req_data  in  N_REQ*32  requester i data on bits [32*i+31:32*i].
- gnt  out  N_REQ  one-cycle grant pulse; one-hot or zero.
- sw_ack  in  1  software acknowledge; a toggle of this level is one ack.
- user_data_out  out  32  latched data word.
- status_out  out  32  {valid, timeout_cnt[6:0], 5'b0, src_id[2:0], seq[15:0]}.

Behaviour:
- Reset (OPB_Rst=0, asynchronous):
  - gnt=0, user_data_out=0, status_out=0.
  - state=IDLE, rr_ptr=0, seq=0, timeout_cnt=0, hold_cnt=0, ack_pend=0.
  - ack_prev loads sw_ack on the first clock after reset release.
- States are IDLE and WAIT_ACK.
- IDLE:
  - If any req bit is set at edge k, select the first set index i searching circularly from rr_ptr.
  - At edge k: user_data_out=req_data[i], src_id=i, seq=seq+1 (16-bit wrap 0xFFFF->0x0000), valid=1, gnt[i]=1 for exactly one cycle.
  - Also at edge k: rr_ptr=(i+1) mod N_REQ, hold_cnt=0, ack_pend=0, go to WAIT_ACK.
  - Latency from req to gnt/valid is 1 cycle.
- Requester contract: hold req and req_data stable until gnt, then drop req the cycle after gnt. If req is still high in the next IDLE, it is a new request.
- WAIT_ACK:
  - Outputs are frozen; gnt=0.
  - hold_cnt increments and saturates at HOLD_CYCLES.
  - An sw_ack toggle (sw_ack != ack_prev) sets ack_pend; ack_prev tracks sw_ack every cycle in all states.
  - Release when hold_cnt >= HOLD_CYCLES-1 and (ack_pend or toggle this cycle): valid=0 at that edge, go to IDLE. user_data_out, src_id and seq keep their last values.
  - Timeout: if ACK_TIMEOUT != 0 and cycles in WAIT_ACK reach ACK_TIMEOUT with no ack, force release. timeout_cnt increments and saturates at 127.
  - Ack and timeout in the same cycle: ack wins, no timeout count.
- The earliest re-grant is the cycle after release; IDLE lasts at least 1 cycle, so back-to-back words are separated by >= HOLD_CYCLES+1 cycles.
- Toggles in IDLE update ack_prev only. A stale ack never pre-acknowledges the next word.
- Simultaneous requests are served strictly in round-robin order. No requester can be granted twice while another continuously requesting one is waiting.
- N_REQ=1: src_id is always 0 and rr_ptr stays 0.
- Unused src_id bits are 0.
- Reset mid-WAIT_ACK: everything returns to reset values immediately. No gnt is issued during reset.

Test Plan:
- Reset, then req=4'b0001 with req_data[31:0]=0xDEADBEEF -> gnt=0001 one cycle later for 1 cycle; user_data_out=0xDEADBEEF; status_out=0x80000001.
- Toggle sw_ack 3 cycles after grant, HOLD_CYCLES=16 -> valid stays 1 until hold expires (16 cycles in WAIT_ACK), then drops; no further gnt.
- req=4'b1111 held continuously, ack each word -> grant order 0,1,2,3,0; seq 1..5; src_id matches.
- ACK_TIMEOUT=32, no ack -> valid drops after 32 cycles; timeout_cnt=1; 128 timeouts -> saturates at 127.
- Toggle sw_ack while IDLE, then request -> word is not released until a fresh toggle arrives.
- seq preset by issuing 65535 words, then one more -> seq wraps to 0x0000; OPB_Rst pulsed low mid-WAIT_ACK -> all outputs 0 asynchronously.
